// File: rtl/coreapb3_iaddr_xfer.sv
// APB3 slave register block that launches one APB3 master transfer to IADDR per START.
// The master side runs SETUP then ACCESS, with an optional wait-state timeout.
module coreapb3_iaddr_xfer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int APB_DWIDTH     = 32
) (
    input  logic                  PCLK,
    input  logic                  PRESETN,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [3:0]            PADDR,
    input  logic [APB_DWIDTH-1:0] PWDATA,
    output logic [APB_DWIDTH-1:0] PRDATA,
    input  logic [31:0]           IADDR,
    output logic                  M_PSEL,
    output logic                  M_PENABLE,
    output logic                  M_PWRITE,
    output logic [31:0]           M_PADDR,
    output logic [APB_DWIDTH-1:0] M_PWDATA,
    input  logic [APB_DWIDTH-1:0] M_PRDATA,
    input  logic                  M_PREADY,
    input  logic                  M_PSLVERR,
    output logic                  IRQ
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    // Last wait-counter value before the abort fires, so ACCESS lasts TIMEOUT_CYCLES cycles.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t                  state_q;
    logic [7:0]              wcnt_q;
    logic                    m_psel_q, m_penable_q, m_pwrite_q;
    logic [31:0]             m_paddr_q;
    logic [APB_DWIDTH-1:0]   m_pwdata_q;

    logic [APB_DWIDTH-1:0]   data_q, data_d;
    logic                    dir_q, dir_d;
    logic                    ie_q, ie_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    tmo_q, tmo_d;

    logic wr_en, wr_data, wr_ctrl, wr_stat;
    logic idle, start, xfer_done, xfer_tmo;
    logic unused_paddr_lsb;

    assign unused_paddr_lsb = ^PADDR[1:0];

    assign wr_en     = PSEL & PENABLE & PWRITE;
    assign wr_data   = wr_en & (PADDR[3:2] == 2'd0);
    assign wr_ctrl   = wr_en & (PADDR[3:2] == 2'd1);
    assign wr_stat   = wr_en & (PADDR[3:2] == 2'd2);
    assign idle      = (state_q == IDLE);
    assign start     = wr_ctrl & idle & PWDATA[0];
    assign xfer_done = (state_q == ACCESS) & M_PREADY;
    assign xfer_tmo  = (state_q == ACCESS) & ~M_PREADY & (wcnt_q == TMO_LAST);

    always_comb begin
        PRDATA = '0;
        case (PADDR[3:2])
            2'd0:    PRDATA = data_q;
            2'd1:    PRDATA = APB_DWIDTH'({ie_q, dir_q, 1'b0});
            2'd2:    PRDATA = APB_DWIDTH'({tmo_q, err_q, done_q, ~idle});
            default: PRDATA = '0;
        endcase
    end

    // Hardware sets are ORed in after the W1C mask so a same-cycle set wins.
    always_comb begin
        data_d = data_q;
        dir_d  = dir_q;
        ie_d   = ie_q;
        if (wr_data && idle)
            data_d = PWDATA;
        if (xfer_done && !m_pwrite_q)
            data_d = M_PRDATA;
        if (wr_ctrl && idle) begin
            dir_d = PWDATA[1];
            ie_d  = PWDATA[2];
        end
        done_d = (done_q & ~(wr_stat & PWDATA[1])) | xfer_done | xfer_tmo;
        err_d  = (err_q  & ~(wr_stat & PWDATA[2])) | (xfer_done & M_PSLVERR);
        tmo_d  = (tmo_q  & ~(wr_stat & PWDATA[3])) | xfer_tmo;
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            data_q <= '0;
            dir_q  <= 1'b0;
            ie_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            tmo_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            dir_q  <= dir_d;
            ie_q   <= ie_d;
            done_q <= done_d;
            err_q  <= err_d;
            tmo_q  <= tmo_d;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            m_psel_q    <= 1'b0;
            m_penable_q <= 1'b0;
            m_pwrite_q  <= 1'b0;
            m_paddr_q   <= '0;
            m_pwdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= SETUP;
                        m_psel_q    <= 1'b1;
                        m_penable_q <= 1'b0;
                        m_paddr_q   <= IADDR;
                        m_pwrite_q  <= PWDATA[1];
                        m_pwdata_q  <= data_q;
                    end
                end
                SETUP: begin
                    state_q     <= ACCESS;
                    m_penable_q <= 1'b1;
                    wcnt_q      <= '0;
                end
                ACCESS: begin
                    if (xfer_done || xfer_tmo) begin
                        state_q     <= IDLE;
                        m_psel_q    <= 1'b0;
                        m_penable_q <= 1'b0;
                    end else begin
                        wcnt_q <= wcnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    m_psel_q    <= 1'b0;
                    m_penable_q <= 1'b0;
                end
            endcase
        end
    end

    assign M_PSEL    = m_psel_q;
    assign M_PENABLE = m_penable_q;
    assign M_PWRITE  = m_pwrite_q;
    assign M_PADDR   = m_paddr_q;
    assign M_PWDATA  = m_pwdata_q;
    assign IRQ       = done_q & ie_q;

endmodule
